// File: rtl/slew_sched_pkg.sv
// slew_sched_pkg: shared types and constants for the setpoint scheduler.
package slew_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLEW = 2'd1,
    DONE = 2'd2
  } state_e;

  // Shortest tick slot; must cover the limiter's motion latency.
  localparam int MIN_PERIOD = 3;
  localparam int MOTION_LAT = 3;

endpackage

// File: rtl/slew_sched_if.sv
// slew_sched_if: host handshake and limiter-side bundle of the scheduler.
interface slew_sched_if #(
  parameter int dw = 16,
  parameter int pw = 16,
  parameter int tw = 24
);

  logic [dw-1:0] set_val;
  logic          set_valid;
  logic          set_ready;
  logic [pw-1:0] period;
  logic          wrap_in;
  logic          bypass;
  logic [tw-1:0] timeout_lim;
  logic          motion;
  logic [dw-1:0] out_set;
  logic          out_enable;
  logic          out_wrap;
  logic          tick;
  logic          busy;
  logic          done;
  logic          timeout;

  modport slave (
    input  set_val,
    input  set_valid,
    output set_ready,
    input  period,
    input  wrap_in,
    input  bypass,
    input  timeout_lim,
    input  motion,
    output out_set,
    output out_enable,
    output out_wrap,
    output tick,
    output busy,
    output done,
    output timeout
  );

  modport master (
    output set_val,
    output set_valid,
    input  set_ready,
    output period,
    output wrap_in,
    output bypass,
    output timeout_lim,
    output motion,
    input  out_set,
    input  out_enable,
    input  out_wrap,
    input  tick,
    input  busy,
    input  done,
    input  timeout
  );

endinterface

// File: rtl/slew_tick_div.sv
// slew_tick_div: loadable down-counter emitting a slot strobe every P clocks.
module slew_tick_div #(
  parameter int pw = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [pw-1:0] period,
  input  logic          run,
  output logic          slot
);

  logic [pw-1:0] per_q;
  logic [pw-1:0] cnt_q;
  logic [pw-1:0] cnt_d;

  assign slot = run & ~load & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = period - pw'(1);
    end else if (slot) begin
      cnt_d = per_q - pw'(1);
    end else if (run) begin
      cnt_d = cnt_q - pw'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        per_q <= period;
      end
    end
  end

endmodule

// File: rtl/slew_sched.sv
// slew_sched: paces limiter ticks and reports move completion.
// Define SLEW_SCHED_TIMEOUT_EN to build the per-move tick limit.
module slew_sched
  import slew_sched_pkg::*;
#(
  parameter int dw = 16,
  parameter int pw = 16,
  parameter int tw = 24
) (
  input logic         clk,
  input logic         rst_n,
  slew_sched_if.slave mif
);

  state_e state_q;
  state_e state_d;

  logic [dw-1:0] set_q;
  logic          wrap_q;
  logic          en_q;
  logic          tick_q;
  logic          tick_d;
  logic          tmo_q;
  logic          tmo_d;
  logic          accept;
  logic          run;
  logic          slot;
  logic          hit;
  logic [pw-1:0] eff_p;

  assign accept = mif.set_valid & (state_q == IDLE);
  assign run    = (state_q == SLEW);

  assign eff_p = (mif.period < pw'(MIN_PERIOD))
               ? pw'(MIN_PERIOD)
               : mif.period;

  slew_tick_div #(
    .pw(pw)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .period (eff_p),
    .run    (run),
    .slot   (slot)
  );

`ifdef SLEW_SCHED_TIMEOUT_EN
  logic [tw-1:0] cnt_q;
  logic [tw-1:0] lim_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      lim_q <= mif.timeout_lim;
    end else if (tick_d) begin
      cnt_q <= cnt_q + tw'(1);
    end
  end

  // Limit of zero means unlimited.
  assign hit = (lim_q != '0) && (cnt_q == lim_q);
`else
  logic unused_lim;

  assign unused_lim = ^mif.timeout_lim;
  assign hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SLEW;
        end
      end
      SLEW: begin
        if (slot) begin
          if (!mif.motion) begin
            state_d = DONE;
          end else if (hit) begin
            state_d = IDLE;
            tmo_d   = 1'b1;
          end else begin
            tick_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q  <= '0;
      wrap_q <= 1'b0;
      en_q   <= 1'b0;
      tick_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      tmo_q  <= tmo_d;
      if (accept) begin
        set_q  <= mif.set_val;
        wrap_q <= mif.wrap_in;
        en_q   <= ~mif.bypass;
      end
    end
  end

  assign mif.out_set    = set_q;
  assign mif.out_wrap   = wrap_q;
  assign mif.out_enable = en_q;
  assign mif.tick       = tick_q;
  assign mif.timeout    = tmo_q;
  assign mif.set_ready  = (state_q == IDLE);
  assign mif.busy       = (state_q != IDLE);
  assign mif.done       = (state_q == DONE);

  a_tick_gap: assert property (
    @(posedge clk) disable iff (!rst_n)
    mif.tick |=> !mif.tick ##1 !mif.tick
  );

  a_done_pulse: assert property (
    @(posedge clk) disable iff (!rst_n)
    mif.done |=> !mif.done && mif.set_ready
  );

endmodule

// File: tb/tb_slew_sched.sv
// tb_slew_sched: table, directed and random moves against a limiter model.
module tb_slew_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  slew_sched_if mif ();

  slew_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (mif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_tick = -100;
  int cur_m   = 0;
  int acc_q[$];
  int tick_q[$];
  int done_q[$];
  int tmo_q[$];

  // Behavioural slew limiter: unit steps, jump when disabled.
  logic [15:0] lm_set;
  logic [15:0] lm_cur;
  logic        lm_mot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lm_set <= '0;
      lm_cur <= '0;
      lm_mot <= 1'b0;
    end else begin
      lm_set <= mif.out_set;
      lm_mot <= (lm_cur != lm_set);
      if (mif.tick) begin
        if (!mif.out_enable) lm_cur <= lm_set;
        else if (lm_cur < lm_set) lm_cur <= lm_cur + 16'd1;
        else if (lm_cur > lm_set) lm_cur <= lm_cur - 16'd1;
      end
    end
  end

  assign mif.motion = lm_mot;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mif.set_valid && mif.set_ready) acc_q.push_back(cyc + 1);
      if (mif.tick) begin
        check("tick_gap_ge3", 32'(cyc - last_tick >= 3), 32'd1);
        last_tick = cyc;
        tick_q.push_back(cyc);
      end
      if (mif.done) done_q.push_back(cyc);
      if (mif.timeout) tmo_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int tgt; int per; bit byp; bit wr;
    int k;   int p;   int lat;
  } vec_t;

  vec_t tbl[7];

  function automatic void predict(input int cur, input int tgt,
                                  input int per, input bit byp,
                                  input int lim, output int k,
                                  output int p, output int lat,
                                  output bit to, output int fin);
    int d;
    p   = (per < 3) ? 3 : per;
    d   = (tgt > cur) ? tgt - cur : cur - tgt;
    k   = byp ? int'(d != 0) : d;
    to  = 1'b0;
    fin = tgt;
`ifdef SLEW_SCHED_TIMEOUT_EN
    if (lim != 0 && k > lim) begin
      to  = 1'b1;
      k   = lim;
      fin = (tgt > cur) ? cur + lim : cur - lim;
    end
`endif
    lat = p * (k + 1);
  endfunction

  task automatic clear_mon();
    acc_q.delete();
    tick_q.delete();
    done_q.delete();
    tmo_q.delete();
  endtask

  task automatic drive(input int tgt, input int per, input bit byp,
                       input bit wr, input int lim);
    mif.set_val     = 16'(tgt);
    mif.period      = 16'(per);
    mif.bypass      = byp;
    mif.wrap_in     = wr;
    mif.timeout_lim = 24'(lim);
    mif.set_valid   = 1'b1;
  endtask

  task automatic scramble();
    mif.period      = 16'($urandom_range(9));
    mif.bypass      = 1'($urandom);
    mif.wrap_in     = 1'($urandom);
    mif.timeout_lim = 24'($urandom_range(1, 3));
  endtask

  task automatic wait_acc(input string nm, input int cnt,
                          output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (acc_q.size() >= cnt) begin
        ok = 1'b1;
        n  = acc_q[cnt-1];
        break;
      end
    end
    if (!ok) check({nm, "/accept"}, 32'd0, 32'd1);
  endtask

  task automatic wait_end(input string nm, input int cnt,
                          input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_q.size() + tmo_q.size() >= cnt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({nm, "/end"}, 32'd0, 32'd1);
  endtask

  task automatic run_move(input string nm, input int tgt,
                          input int per, input bit byp, input bit wr,
                          input int lim, input int k, input int p,
                          input int lat, input bit to, input int fin);
    int n;
    bit ok;
    clear_mon();
    @(posedge clk); #2;
    drive(tgt, per, byp, wr, lim);
    wait_acc(nm, 1, n, ok);
    mif.set_valid = 1'b0;
    scramble();
    if (ok) begin
      wait_end(nm, 1, lat + 20, ok);
      check({nm, "/ticks"}, tick_q.size(), k);
      for (int j = 0; j < tick_q.size() && j < k; j++)
        check({nm, "/tick_t"}, tick_q[j], n + p * (j + 1));
      check({nm, "/done_n"}, done_q.size(), 32'(!to));
      check({nm, "/tmo_n"}, tmo_q.size(), 32'(to));
      if (!to && done_q.size() > 0)
        check({nm, "/done_t"}, done_q[0], n + lat);
      if (to && tmo_q.size() > 0)
        check({nm, "/tmo_t"}, tmo_q[0], n + lat);
      check({nm, "/out_set"}, mif.out_set, tgt);
      check({nm, "/out_en"}, mif.out_enable, 32'(!byp));
      check({nm, "/out_wrap"}, mif.out_wrap, 32'(wr));
      @(negedge clk);
      check({nm, "/ready"}, mif.set_ready, 32'd1);
      check({nm, "/busy"}, mif.busy, 32'd0);
      check({nm, "/lim_out"}, lm_cur, fin);
    end
    cur_m = fin;
  endtask

  initial begin
    int n1, n2, k, p, lat, fin;
    bit ok, to;

    tbl[0] = '{5,   4, 0, 0, 5, 4, 24};
    tbl[1] = '{5,   4, 0, 0, 0, 4, 4};
    tbl[2] = '{0,   0, 0, 1, 5, 3, 18};
    tbl[3] = '{3,   1, 0, 0, 3, 3, 12};
    tbl[4] = '{3,   7, 0, 0, 0, 7, 7};
    tbl[5] = '{100, 3, 1, 0, 1, 3, 6};
    tbl[6] = '{98,  5, 0, 0, 2, 5, 15};

    mif.set_val     = '0;
    mif.set_valid   = 1'b0;
    mif.period      = '0;
    mif.wrap_in     = 1'b0;
    mif.bypass      = 1'b0;
    mif.timeout_lim = '0;

    repeat (3) @(posedge clk);
    #2;
    check("rst/ready", mif.set_ready, 32'd1);
    check("rst/busy", mif.busy, 32'd0);
    check("rst/tick", mif.tick, 32'd0);
    check("rst/done", mif.done, 32'd0);
    check("rst/timeout", mif.timeout, 32'd0);
    check("rst/out_set", mif.out_set, 32'd0);
    check("rst/out_en", mif.out_enable, 32'd0);
    check("rst/out_wrap", mif.out_wrap, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_move($sformatf("tbl%0d", i), tbl[i].tgt, tbl[i].per,
               tbl[i].byp, tbl[i].wr, 0, tbl[i].k, tbl[i].p,
               tbl[i].lat, 1'b0, tbl[i].tgt);

    // Second request held while the first move is in flight.
    clear_mon();
    @(posedge clk); #2;
    drive(94, 3, 1'b0, 1'b0, 0);
    wait_acc("hold1", 1, n1, ok);
    mif.set_val = 16'd7;
    mif.bypass  = 1'b1;
    wait_acc("hold2", 2, n2, ok);
    mif.set_valid = 1'b0;
    wait_end("hold", 2, 60, ok);
    check("hold/done_n", done_q.size(), 32'd2);
    check("hold/ticks", tick_q.size(), 32'd5);
    if (done_q.size() >= 1) begin
      check("hold/done1_t", done_q[0], n1 + 15);
      check("hold/acc2_t", n2, done_q[0] + 2);
    end
    if (done_q.size() >= 2)
      check("hold/done2_t", done_q[1], n2 + 6);
    if (tick_q.size() >= 5)
      check("hold/byp_tick_t", tick_q[4], n2 + 3);
    @(negedge clk);
    check("hold/lim_out", lm_cur, 32'd7);
    check("hold/out_en", mif.out_enable, 32'd0);
    cur_m = 7;

    predict(cur_m, 17, 3, 1'b0, 2, k, p, lat, to, fin);
    run_move("tmo", 17, 3, 1'b0, 1'b0, 2, k, p, lat, to, fin);

    // Reset while a move is mid-flight.
    clear_mon();
    @(posedge clk); #2;
    drive(cur_m + 20, 4, 1'b0, 1'b1, 0);
    wait_acc("mrst", 1, n1, ok);
    mif.set_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (mif.tick) begin
        ok = 1'b1;
        break;
      end
    end
    check("mrst/saw_tick", 32'(ok), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst/tick", mif.tick, 32'd0);
    check("mrst/busy", mif.busy, 32'd0);
    check("mrst/out_set", mif.out_set, 32'd0);
    check("mrst/out_wrap", mif.out_wrap, 32'd0);
    check("mrst/done", mif.done, 32'd0);
    check("mrst/timeout", mif.timeout, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_mon();
    cur_m = 0;
    repeat (6) @(negedge clk);
    check("mrst/no_done", done_q.size(), 32'd0);
    check("mrst/no_tmo", tmo_q.size(), 32'd0);
    check("mrst/no_tick", tick_q.size(), 32'd0);
    predict(cur_m, 6, 3, 1'b0, 0, k, p, lat, to, fin);
    run_move("post_rst", 6, 3, 1'b0, 1'b0, 0, k, p, lat, to, fin);

    for (int i = 0; i < 24; i++) begin
      int t, per, lim;
      bit byp, wr;
      t = cur_m + int'($urandom_range(16)) - 8;
      if (t < 0) t = 0;
      per = int'($urandom_range(6));
      byp = ($urandom_range(3) == 0);
      wr  = 1'($urandom);
      lim = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(1, 5));
      predict(cur_m, t, per, byp, lim, k, p, lat, to, fin);
      run_move($sformatf("rnd%0d", i), t, per, byp, wr, lim,
               k, p, lat, to, fin);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
